neuron_multilane: RTL and testbench

//  Multi-lane successor to the single-MAC neuron. Computes the signed dot product of up to

---
 rtl/neuron_multilane_if.sv | 37 +++
 rtl/neuron_multilane.sv | 180 ++++++++++++++++++
 tb/tb_neuron_multilane.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_multilane_if.sv
// Operand/result handshake bundle for neuron_multilane: count n, activations, weights and result.
interface neuron_multilane_if #(
  parameter int NEURON_NUM          = 5,
  parameter int ACTIVATION_WIDTH    = 9,
  parameter int WEIGHT_CELL_WIDTH   = 16,
  parameter int NEURON_OUTPUT_WIDTH = 10
) ();
  localparam int NW = $clog2(NEURON_NUM) + 1;

  logic [NW-1:0]                           input_number;
  logic                                    input_number_valid;
  logic                                    input_number_ready;
  logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]  inputs;
  logic                                    inputs_valid;
  logic                                    inputs_ready;
  logic [NEURON_NUM*WEIGHT_CELL_WIDTH-1:0] weights;
  logic                                    weights_valid;
  logic                                    weights_ready;
  logic [NEURON_OUTPUT_WIDTH-1:0]          neuron_sum;
  logic                                    overflow;
  logic                                    neuron_sum_valid;
  logic                                    neuron_sum_ready;

  modport master (
    output input_number, input_number_valid, inputs, inputs_valid,
           weights, weights_valid, neuron_sum_ready,
    input  input_number_ready, inputs_ready, weights_ready,
           neuron_sum, overflow, neuron_sum_valid
  );

  modport slave (
    input  input_number, input_number_valid, inputs, inputs_valid,
           weights, weights_valid, neuron_sum_ready,
    output input_number_ready, inputs_ready, weights_ready,
           neuron_sum, overflow, neuron_sum_valid
  );
endinterface

// File: rtl/neuron_multilane.sv
// Multi-lane signed dot product: LANES products per CALC cycle into one wide accumulator.
// Define NEURON_MULTILANE_SATURATE_EN to clamp neuron_sum on overflow instead of wrapping.
// state | meaning
// IDLE  | collecting n, activations and weights in any order
// CALC  | accumulating LANES products per cycle
// DONE  | result presented, waiting for neuron_sum_ready
module neuron_multilane #(
  parameter int NEURON_NUM          = 5,
  parameter int LANES               = 2,
  parameter int ACTIVATION_WIDTH    = 9,
  parameter int WEIGHT_CELL_WIDTH   = 16,
  parameter int NEURON_OUTPUT_WIDTH = 10,
  parameter int FRACTION            = 0
) (
  input logic clk,
  input logic rst,
  neuron_multilane_if.slave bus
);
  localparam int AW        = ACTIVATION_WIDTH;
  localparam int WW        = WEIGHT_CELL_WIDTH;
  localparam int OW        = NEURON_OUTPUT_WIDTH;
  localparam int PW        = AW + WW;
  localparam int NW        = $clog2(NEURON_NUM) + 1;
  localparam int ACC_WIDTH = WW + AW + $clog2(NEURON_NUM) + 1;
  localparam int CW        = $clog2(NEURON_NUM + LANES + 1) + 1;
  localparam int HI        = OW + FRACTION - 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;

  state_e                      state_q, state_d;
  logic                        n_set_q, n_set_d, in_set_q, in_set_d, w_set_q, w_set_d;
  logic [NW-1:0]               n_buf_q, n_buf_d;
  logic [NEURON_NUM*AW-1:0]    act_buf_q, act_buf_d;
  logic [NEURON_NUM*WW-1:0]    w_buf_q, w_buf_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]               counter_q, counter_d;

  logic [CW-1:0]               n_eff;
  logic [CW-1:0]               idx;
  logic signed [AW-1:0]        a_sel;
  logic signed [WW-1:0]        w_sel;
  logic signed [PW-1:0]        prod;
  logic signed [ACC_WIDTH-1:0] lane_sum;
  logic                        n_xfer, in_xfer, w_xfer;
  logic [ACC_WIDTH-1:HI]       top_bits;
  logic                        ovf;
  logic [OW-1:0]               sum_out;

  always_comb begin
    n_eff = (n_buf_q > NW'(NEURON_NUM)) ? CW'(NEURON_NUM) : CW'(n_buf_q);
  end

  // Lanes beyond n_eff add nothing, so stale data in unused lanes never reaches acc.
  always_comb begin
    lane_sum = '0;
    idx      = '0;
    a_sel    = '0;
    w_sel    = '0;
    prod     = '0;
    for (int l = 0; l < LANES; l++) begin
      idx   = counter_q + CW'(l);
      a_sel = '0;
      w_sel = '0;
      for (int j = 0; j < NEURON_NUM; j++) begin
        if (idx == CW'(j)) begin
          a_sel = act_buf_q[j*AW +: AW];
          w_sel = w_buf_q[j*WW +: WW];
        end
      end
      prod = a_sel * w_sel;
      if (idx < n_eff) begin
        lane_sum = lane_sum + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
      end
    end
  end

  always_comb begin
    n_xfer  = bus.input_number_valid && !n_set_q;
    in_xfer = bus.inputs_valid && !in_set_q;
    w_xfer  = bus.weights_valid && !w_set_q;

    state_d   = state_q;
    n_set_d   = n_set_q;
    in_set_d  = in_set_q;
    w_set_d   = w_set_q;
    n_buf_d   = n_buf_q;
    act_buf_d = act_buf_q;
    w_buf_d   = w_buf_q;
    acc_d     = acc_q;
    counter_d = counter_q;

    case (state_q)
      IDLE: begin
        if (n_xfer) begin
          n_set_d = 1'b1;
          n_buf_d = bus.input_number;
        end
        if (in_xfer) begin
          in_set_d  = 1'b1;
          act_buf_d = bus.inputs;
        end
        if (w_xfer) begin
          w_set_d = 1'b1;
          w_buf_d = bus.weights;
        end
        if ((n_set_q || n_xfer) && (in_set_q || in_xfer) && (w_set_q || w_xfer)) begin
          state_d   = CALC;
          acc_d     = '0;
          counter_d = '0;
        end
      end
      CALC: begin
        acc_d     = acc_q + lane_sum;
        counter_d = counter_q + CW'(LANES);
        if (counter_q + CW'(LANES) >= n_eff) state_d = DONE;
      end
      DONE: begin
        if (bus.neuron_sum_ready) begin
          state_d   = IDLE;
          acc_d     = '0;
          counter_d = '0;
          n_set_d   = 1'b0;
          in_set_d  = 1'b0;
          w_set_d   = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        acc_d     = '0;
        counter_d = '0;
        n_set_d   = 1'b0;
        in_set_d  = 1'b0;
        w_set_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      n_set_q   <= 1'b0;
      in_set_q  <= 1'b0;
      w_set_q   <= 1'b0;
      n_buf_q   <= '0;
      act_buf_q <= '0;
      w_buf_q   <= '0;
      acc_q     <= '0;
      counter_q <= '0;
    end else begin
      state_q   <= state_d;
      n_set_q   <= n_set_d;
      in_set_q  <= in_set_d;
      w_set_q   <= w_set_d;
      n_buf_q   <= n_buf_d;
      act_buf_q <= act_buf_d;
      w_buf_q   <= w_buf_d;
      acc_q     <= acc_d;
      counter_q <= counter_d;
    end
  end

  // Fits only when every bit from the output sign position upward matches.
  always_comb begin
    top_bits = acc_q[ACC_WIDTH-1:HI];
    ovf      = !((&top_bits) || !(|top_bits));
    sum_out  = acc_q[HI:FRACTION];
`ifdef NEURON_MULTILANE_SATURATE_EN
    if (ovf) begin
      sum_out = acc_q[ACC_WIDTH-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    end
`endif
  end

  assign bus.input_number_ready = !n_set_q;
  assign bus.inputs_ready       = !in_set_q;
  assign bus.weights_ready      = !w_set_q;
  assign bus.neuron_sum         = sum_out;
  assign bus.neuron_sum_valid   = (state_q == DONE);
  assign bus.overflow           = ovf && (state_q == DONE);
endmodule

// File: tb/tb_neuron_multilane.sv
// Self-checking bench for neuron_multilane: vector table, random jobs and multi-cycle corner sequences.
module tb_neuron_multilane;
`ifdef NEURON_MULTILANE_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  neuron_multilane_if #(.NEURON_NUM(5), .ACTIVATION_WIDTH(9), .WEIGHT_CELL_WIDTH(16),
                        .NEURON_OUTPUT_WIDTH(10)) bus ();

  neuron_multilane #(.NEURON_NUM(5), .LANES(2), .ACTIVATION_WIDTH(9), .WEIGHT_CELL_WIDTH(16),
                     .NEURON_OUTPUT_WIDTH(10), .FRACTION(0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    int         n;
    int         a[5];
    int         w[5];
    logic [9:0] s;
    logic       o;
  } vec_t;

  typedef struct {
    logic [9:0] s;
    logic       o;
    int         lat;
    int         k;
  } exp_t;

  vec_t vt[8];
  exp_t sbq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [44:0] pack_a(input int a[5]);
    logic [44:0] r;
    for (int i = 0; i < 5; i++) r[i*9 +: 9] = 9'(a[i]);
    return r;
  endfunction

  function automatic logic [79:0] pack_w(input int w[5]);
    logic [79:0] r;
    for (int i = 0; i < 5; i++) r[i*16 +: 16] = 16'(w[i]);
    return r;
  endfunction

  function automatic int calc_cycles(input int n);
    int ne;
    ne = (n > 5) ? 5 : n;
    return (ne == 0) ? 1 : (ne + 1) / 2;
  endfunction

  function automatic void model(input int n, input int a[5], input int w[5],
                                output logic [9:0] s, output logic o);
    longint acc;
    int     ne;
    acc = 0;
    ne  = (n > 5) ? 5 : n;
    for (int i = 0; i < ne; i++) acc += longint'(a[i]) * longint'(w[i]);
    o = (acc > 511) || (acc < -512);
    s = acc[9:0];
    if (o && SAT) s = (acc < 0) ? 10'h200 : 10'h1FF;
  endfunction

  task automatic send(input int n, input logic [44:0] ap, input logic [79:0] wp,
                      input logic [9:0] es, input logic eo, input bit push);
    int k;
    @(negedge clk);
    check("ready_before_send",
          {29'd0, bus.input_number_ready, bus.inputs_ready, bus.weights_ready}, 32'd7);
    bus.input_number       = 4'(n);
    bus.inputs             = ap;
    bus.weights            = wp;
    bus.input_number_valid = 1'b1;
    bus.inputs_valid       = 1'b1;
    bus.weights_valid      = 1'b1;
    @(negedge clk);
    k = cyc;
    bus.input_number_valid = 1'b0;
    bus.inputs_valid       = 1'b0;
    bus.weights_valid      = 1'b0;
    check("ready_low_in_calc",
          {29'd0, bus.input_number_ready, bus.inputs_ready, bus.weights_ready}, 32'd0);
    if (push) sbq.push_back('{s: es, o: eo, lat: calc_cycles(n), k: k});
  endtask

  task automatic get_result(input int hold);
    int         budget;
    exp_t       e;
    logic [9:0] held;
    budget = 0;
    while (!bus.neuron_sum_valid && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    check("result_valid", {31'd0, bus.neuron_sum_valid}, 32'd1);
    if (!bus.neuron_sum_valid) return;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_result actual=%0h expected=none", bus.neuron_sum);
      return;
    end
    e = sbq.pop_front();
    check("latency", 32'(cyc - e.k), 32'(e.lat));
    check("neuron_sum", {22'd0, bus.neuron_sum}, {22'd0, e.s});
    check("overflow", {31'd0, bus.overflow}, {31'd0, e.o});
    held = bus.neuron_sum;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_sum", {22'd0, bus.neuron_sum}, {22'd0, held});
      check("hold_valid_readies",
            {28'd0, bus.neuron_sum_valid, bus.input_number_ready, bus.inputs_ready,
             bus.weights_ready}, 32'h8);
    end
    bus.neuron_sum_ready = 1'b1;
    @(negedge clk);
    bus.neuron_sum_ready = 1'b0;
    check("after_handshake",
          {28'd0, bus.neuron_sum_valid, bus.input_number_ready, bus.inputs_ready,
           bus.weights_ready}, 32'h7);
  endtask

  initial begin
    int         ra[5];
    int         rw[5];
    int         rn;
    int         k;
    logic [9:0] es;
    logic       eo;

    vt[0] = '{n: 5, a: '{1, 1, 1, 1, 1}, w: '{1, 2, 3, 4, 5}, s: 10'd15, o: 1'b0};
    vt[1] = '{n: 3, a: '{2, 2, 2, -1, -1}, w: '{-1, -2, -3, 32767, 32767}, s: 10'h3F4, o: 1'b0};
    vt[2] = '{n: 2, a: '{255, 255, 0, 0, 0}, w: '{32767, 32767, 0, 0, 0},
              s: SAT ? 10'h1FF : 10'h202, o: 1'b1};
    vt[3] = '{n: 7, a: '{1, -1, 3, 2, 4}, w: '{10, 20, -5, 7, 1}, s: 10'h3F9, o: 1'b0};
    vt[4] = '{n: 0, a: '{100, 100, 100, 100, 100}, w: '{99, 99, 99, 99, 99}, s: 10'd0, o: 1'b0};
    vt[5] = '{n: 1, a: '{-256, 7, 7, 7, 7}, w: '{-32768, 7, 7, 7, 7},
              s: SAT ? 10'h1FF : 10'h000, o: 1'b1};
    vt[6] = '{n: 4, a: '{-3, 5, -7, 2, 100}, w: '{100, -50, 9, -1000, 100},
              s: SAT ? 10'h200 : 10'h1CB, o: 1'b1};
    vt[7] = '{n: 5, a: '{-1, -1, -1, -1, -1}, w: '{-1, -1, -1, -1, -1}, s: 10'd5, o: 1'b0};

    bus.input_number       = '0;
    bus.input_number_valid = 1'b0;
    bus.inputs             = '0;
    bus.inputs_valid       = 1'b0;
    bus.weights            = '0;
    bus.weights_valid      = 1'b0;
    bus.neuron_sum_ready   = 1'b0;

    #12;
    check("reset_state",
          {17'd0, bus.neuron_sum, bus.overflow, bus.neuron_sum_valid, bus.input_number_ready,
           bus.inputs_ready, bus.weights_ready}, 32'h7);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      send(vt[i].n, pack_a(vt[i].a), pack_w(vt[i].w), vt[i].s, vt[i].o, 1'b1);
      get_result(0);
    end

    // Random jobs checked against the reference model.
    for (int r = 0; r < 10; r++) begin
      rn = int'($urandom_range(0, 7));
      for (int i = 0; i < 5; i++) begin
        ra[i] = int'($urandom_range(0, 511)) - 256;
        rw[i] = int'($urandom_range(0, 80)) - 40;
      end
      model(rn, ra, rw, es, eo);
      send(rn, pack_a(ra), pack_w(rw), es, eo, 1'b1);
      get_result(0);
    end

    // Staggered operands with a repeated inputs_valid while the inputs flag is set.
    ra = '{3, 4, 5, 0, 0};
    rw = '{1, 1, 2, 0, 0};
    @(negedge clk);
    bus.weights       = pack_w(rw);
    bus.weights_valid = 1'b1;
    @(negedge clk);
    bus.weights_valid = 1'b0;
    check("weights_ready_after_capture", {31'd0, bus.weights_ready}, 32'd0);
    bus.inputs        = pack_a(ra);
    bus.inputs_valid  = 1'b1;
    @(negedge clk);
    check("inputs_ready_after_capture", {31'd0, bus.inputs_ready}, 32'd0);
    bus.inputs        = pack_a('{100, 100, 100, 100, 100});
    @(negedge clk);
    bus.inputs_valid       = 1'b0;
    check("still_idle_without_n", {31'd0, bus.input_number_ready}, 32'd1);
    bus.input_number       = 4'd3;
    bus.input_number_valid = 1'b1;
    @(negedge clk);
    k = cyc;
    bus.input_number_valid = 1'b0;
    sbq.push_back('{s: 10'd17, o: 1'b0, lat: 2, k: k});
    get_result(0);
    repeat (6) @(negedge clk);
    check("no_second_result", {31'd0, bus.neuron_sum_valid}, 32'd0);

    // Result held with ready low for 4 cycles.
    send(vt[1].n, pack_a(vt[1].a), pack_w(vt[1].w), vt[1].s, vt[1].o, 1'b1);
    get_result(4);

    // Reset pulsed mid-CALC, then a clean job.
    send(vt[0].n, pack_a(vt[0].a), pack_w(vt[0].w), vt[0].s, vt[0].o, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("reset_mid_calc",
          {28'd0, bus.neuron_sum_valid, bus.input_number_ready, bus.inputs_ready,
           bus.weights_ready}, 32'h7);
    check("reset_mid_calc_state", {30'd0, dut.state_q}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("no_valid_after_reset", {31'd0, bus.neuron_sum_valid}, 32'd0);
    send(vt[0].n, pack_a(vt[0].a), pack_w(vt[0].w), vt[0].s, vt[0].o, 1'b1);
    get_result(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
